// File: rtl/pair_packer_if.sv
// Symbol-in / word-out handshake bundle for pair_packer.
// slave is the packer's view; master is the upstream/downstream driver view.
interface pair_packer_if #(
    parameter int WIDTH = 8
);
    localparam int N      = WIDTH / 2;
    localparam int NSYM_W = $clog2(N) + 1;

    logic              in_valid;
    logic              in0;
    logic              in1;
    logic              in_ready;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [NSYM_W-1:0] out_nsym;

    modport slave (
        input  in_valid, in0, in1, flush, out_ready,
        output in_ready, out_valid, out_data, out_nsym
    );

    modport master (
        output in_valid, in0, in1, flush, out_ready,
        input  in_ready, out_valid, out_data, out_nsym
    );
endinterface

// File: rtl/pair_packer.sv
// Packs 2-bit symbols {in1,in0} LSB-first into WIDTH-bit words behind a
// one-entry output register. Flush emits a zero-padded partial word.
module pair_packer #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    pair_packer_if.slave  bus
);
    localparam int N      = WIDTH / 2;
    localparam int CW     = (N > 1) ? $clog2(N) : 1;
    localparam int NSYM_W = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  acc;
    logic              out_valid_q;
    logic [WIDTH-1:0]  out_data_q;
    logic [NSYM_W-1:0] out_nsym_q;

    logic              slot_free;
    logic              in_ready_c;
    logic              sym_fire;
    logic              flush_fire;
    logic              full;
    logic [NSYM_W-1:0] pend_cnt;
    logic              load;
    logic [WIDTH-1:0]  acc_next;

    // Handshake terms; in_ready is combinational from out_ready so a drain
    // and a completing symbol can share a cycle.
    always_comb begin
        slot_free  = !out_valid_q || bus.out_ready;
        in_ready_c = !rst && (slot_free || (cnt != LAST));
        sym_fire   = bus.in_valid && in_ready_c;
        flush_fire = bus.flush && slot_free && !rst;
        full       = sym_fire && (cnt == LAST);
        pend_cnt   = NSYM_W'(cnt) + NSYM_W'(sym_fire);
        load       = full || (flush_fire && (pend_cnt != '0));
        acc_next   = acc;
        if (sym_fire) begin
            acc_next = acc | (WIDTH'({bus.in1, bus.in0}) << {cnt, 1'b0});
        end
    end

    // Accumulator, slot counter and output register. A load always leaves
    // the accumulator empty, so a flush coinciding with the last symbol
    // yields one full word and nothing after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            acc         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_nsym_q  <= '0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= acc_next;
            out_nsym_q  <= pend_cnt;
            acc         <= '0;
            cnt         <= '0;
        end else begin
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (sym_fire) begin
                acc <= acc_next;
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_nsym  = out_nsym_q;
endmodule

// File: doc/pair_packer.md
# pair_packer

Downstream consumer of the two-bit combinational stage (`comb`). Each cycle it samples `out0`/`out1` as a 2-bit symbol when `in_valid` is high. It packs consecutive symbols LSB-first into `WIDTH`-bit words, which it presents on a valid/ready output port. A flush request emits a zero-padded partial word, so trailing symbols are never stranded.

## Interface
- `WIDTH`, default 8: output word width; must be even and ≥ 2. N = `WIDTH`/2 symbols per word.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `in_valid`  in  1  a symbol is present on `in0`/`in1`.
- `in0`  in  1  symbol bit 0 (driven from `comb.out0`).
- `in1`  in  1  symbol bit 1 (driven from `comb.out1`).
- `in_ready`  out  1  symbol is accepted this cycle if `in_valid` is also high.
- `flush`  in  1  request to emit the partial word; level, held until accepted.
- `out_valid`  out  1  `out_data` and `out_nsym` are valid.
- `out_ready`  in  1  downstream accepts the word this cycle.
- `out_data`  out  `WIDTH`  packed word; symbol k occupies bits [2k+1:2k].
- `out_nsym`  out  $clog2(N)+1  number of valid symbols in `out_data` (1..N).

## Operation
**Symbol format**
- symbol = {`in1`, `in0`}.

**Internal state**
- `cnt`: 0..N-1, the number of symbols held in the accumulator.
- Accumulator register `acc`, `WIDTH` bits.
- Output register: `out_valid`, `out_data`, `out_nsym`.

**Handshake terms**
- slot_free = !`out_valid` || `out_ready`.
- `in_ready` = !`rst` && (slot_free || `cnt` < N-1). This path is combinational from `out_ready`.
- sym_fire = `in_valid` && `in_ready`.
- flush_fire = `flush` && slot_free && !`rst`.

**On sym_fire, without a completing flush**
- The symbol is written into `acc` at slot `cnt`.
- If `cnt` == N-1: the full word moves to the output register with `out_nsym` = N. Then `acc` ← 0 and `cnt` ← 0.
- Otherwise: `cnt` ← `cnt`+1.

**On flush_fire**
- The emitted word is `acc`, plus the same-cycle fired symbol if there is one, zero-padded above the last valid slot.
- `out_nsym` = `cnt` + sym_fire.
- If that count is 0, flush has no effect and no word is emitted.
- After emitting, `acc` ← 0 and `cnt` ← 0.
- Flush at `cnt` == N-1 together with sym_fire emits exactly one full word (`out_nsym` = N). No trailing empty word follows.

**Output register**
- When the output register loads, `out_valid` ← 1.
- Otherwise, if `out_valid` && `out_ready`, then `out_valid` ← 0.
- While `out_valid` && !`out_ready`, `out_data` and `out_nsym` hold stable.
- A drain and a load may occur in the same cycle, which gives back-to-back words.

**Input protocol rules**
- `in_valid` && !`in_ready`: the symbol is not consumed. Upstream holds `in_valid`, `in0` and `in1` stable.
- `flush` is held high by upstream until a cycle where slot_free is 1.

## Timing
**Reset**
- While `rst` is high at an edge: `cnt` = 0, `acc` = 0, `out_valid` = 0, `out_data` = 0, `out_nsym` = 0.
- `in_ready` = 0 while `rst` is high, and 1 in the first cycle after.
- Reset mid-word discards the partial symbols and any pending output word.

**Latency**
- The word is visible on `out_data` with `out_valid` = 1 in the cycle after the completing sym_fire or the flush_fire.

**Throughput**
- One symbol per cycle, sustained, while `out_ready` = 1.
- A word can be emitted every N cycles with no bubbles.

**Backpressure**
- With `out_valid` = 1 and `out_ready` = 0, the block still accepts symbols until `cnt` = N-1.
- `in_ready` then drops to 0, and rises combinationally in the cycle `out_ready` is 1.

## Test plan
All scenarios use `WIDTH` = 8.
1. Reset, then feed symbols 01, 10, 11, 00 on consecutive cycles with `out_ready` = 1 → one cycle after the 4th symbol: `out_valid` = 1, `out_data` = 8'h39, `out_nsym` = 4. During reset: `in_ready` = 0 and `out_valid` = 0.
2. Hold `out_ready` = 0 and stream 8 symbols of 11:
   - First word 8'hFF is held stable.
   - `in_ready` falls after 3 further symbols are accepted.
   - Raise `out_ready` → 8'hFF drains, the 4th symbol is accepted that cycle, and a second 8'hFF appears the next cycle.
3. Feed symbols 11, 01, then pulse `flush` with `in_valid` = 0 → `out_data` = 8'h07, `out_nsym` = 2. `cnt` returns to 0.
4. Feed 3 symbols of 10, then the 4th symbol 10 in the same cycle as `flush` → exactly one word 8'hAA with `out_nsym` = 4, and no second word.
5. `flush` at `cnt` = 0 with `in_valid` = 0 → no `out_valid`. `flush` together with a single symbol 01 → `out_data` = 8'h01, `out_nsym` = 1.
6. Feed 2 symbols, assert `rst` for one cycle, then feed 01, 10, 11, 00 → only 8'h39 is emitted. The pre-reset symbols never appear.
